// File: rtl/pcie_rs_pkg.sv
// Shared types and constants for the PCIe HIP reset sequencer.
// Optional build macro: PCIE_RS_SIM_SHORTCUT_EN (see pcie_rs_hip_seq).
package pcie_rs_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rs_state_t;

  localparam int CAUSE_DLUP   = 0;
  localparam int CAUSE_HOTRST = 1;
  localparam int CAUSE_L2     = 2;
  localparam int CAUSE_LTSSM  = 3;

  localparam logic [4:0] LTSSM_EXIT_DEF = 5'h10;

endpackage

// File: rtl/pcie_rs_sync2.sv
// Two-flop reset synchroniser: async assert, sync deassert.
// Reusable by other HIP wrappers.
module pcie_rs_sync2 (
  input  logic pld_clk,
  input  logic npor,
  output logic rstn
);

  logic meta;

  // shift a constant 1 through two flops once npor is released
  always_ff @(posedge pld_clk or negedge npor) begin
    if (!npor) begin
      meta <= 1'b0;
      rstn <= 1'b0;
    end else begin
      meta <= 1'b1;
      rstn <= meta;
    end
  end

endmodule

// File: rtl/pcie_rs_hip_seq.sv
// Reset sequencer for the PCIe hard IP: hold, staggered release, exit log.
// Optional build macro: PCIE_RS_SIM_SHORTCUT_EN (test_sim shortens hold).
module pcie_rs_hip_seq
  import pcie_rs_pkg::*;
#(
  parameter int         CNT_W       = 11,
  parameter int         HOLD_CYCLES = 1024,
  parameter int         REARM_START = 1008,
  parameter int         SIM_HOLD    = 32,
  parameter int         NUM_APP     = 2,
  parameter int         STAGGER     = 4,
  parameter logic [4:0] LTSSM_EXIT  = LTSSM_EXIT_DEF
) (
  input  logic               pld_clk,
  input  logic               npor,
  input  logic               dlup_exit,
  input  logic               hotrst_exit,
  input  logic               l2_exit,
  input  logic [4:0]         ltssm,
  input  logic               test_sim,
  input  logic               cause_clr,
  output logic               crst,
  output logic               srst,
  output logic [NUM_APP-1:0] app_rstn,
  output logic               rst_busy,
  output logic [3:0]         exit_cause,
  output logic [7:0]         exit_count
);

  localparam int IDX_W = $clog2(NUM_APP + 1);
  localparam int STG_W = $clog2(STAGGER + 2);

  logic any_rstn_rr;

  pcie_rs_sync2 u_sync (
    .pld_clk (pld_clk),
    .npor    (npor),
    .rstn    (any_rstn_rr)
  );

  logic       dlup_r;
  logic       hotrst_r;
  logic       l2_r;
  logic [4:0] ltssm_r;
  logic [3:0] evt_cause;
  logic       exit_evt;

  // register exit inputs, then decode event and its cause bits
  always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
    if (!any_rstn_rr) begin
      dlup_r    <= 1'b1;
      hotrst_r  <= 1'b1;
      l2_r      <= 1'b1;
      ltssm_r   <= '0;
      evt_cause <= '0;
      exit_evt  <= 1'b0;
    end else begin
      dlup_r                 <= dlup_exit;
      hotrst_r               <= hotrst_exit;
      l2_r                   <= l2_exit;
      ltssm_r                <= ltssm;
      evt_cause[CAUSE_DLUP]   <= ~dlup_r;
      evt_cause[CAUSE_HOTRST] <= ~hotrst_r;
      evt_cause[CAUSE_L2]     <= ~l2_r;
      evt_cause[CAUSE_LTSSM]  <= (ltssm_r == LTSSM_EXIT);
      exit_evt <= ~dlup_r | ~hotrst_r | ~l2_r
                | (ltssm_r == LTSSM_EXIT);
    end
  end

  logic [CNT_W-1:0] term;

`ifdef PCIE_RS_SIM_SHORTCUT_EN
  // simulation shortcut shortens the hold interval
  always_comb begin
    term = test_sim ? CNT_W'(SIM_HOLD) : CNT_W'(HOLD_CYCLES);
  end
`else
  logic test_sim_unused;
  assign test_sim_unused = test_sim;

  // terminal count is fixed in normal builds
  always_comb begin
    term = CNT_W'(HOLD_CYCLES);
  end
`endif

  rs_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [STG_W-1:0] stg_q, stg_d;
  logic             crst0_q, crst0_d;
  logic             srst0_q, srst0_d;
  logic [NUM_APP-1:0] app0_q, app0_d;
  logic [3:0]       cause_q, cause_d;
  logic [7:0]       count_q, count_d;

  // sequencer and exit-record state registers
  always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
    if (!any_rstn_rr) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stg_q   <= '0;
      crst0_q <= 1'b1;
      srst0_q <= 1'b1;
      app0_q  <= '0;
      cause_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      crst0_q <= crst0_d;
      srst0_q <= srst0_d;
      app0_q  <= app0_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  // next state: hold, staggered release; exit event overrides all
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stg_d   = stg_q;
    crst0_d = crst0_q;
    srst0_d = srst0_q;
    app0_d  = app0_q;
    cause_d = cause_q;
    count_d = count_q;

    unique case (state_q)
      HOLD: begin
        if (cnt_q >= term) begin
          crst0_d = 1'b0;
          srst0_d = 1'b0;
          idx_d   = '0;
          stg_d   = STG_W'(STAGGER);
          if (STAGGER == 0 || NUM_APP == 1) begin
            app0_d  = '1;
            state_d = RUN;
          end else begin
            app0_d  = app0_q | NUM_APP'(1);
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (int'(idx_q) >= NUM_APP - 1) begin
          state_d = RUN;
        end else if (stg_q == '0) begin
          app0_d = app0_q
                 | (NUM_APP'(1) << (int'(idx_q) + 1));
          idx_d  = idx_q + 1'b1;
          stg_d  = STG_W'(STAGGER);
        end else begin
          stg_d = stg_q - 1'b1;
        end
      end
      RUN: begin
      end
      default: state_d = HOLD;
    endcase

    if (exit_evt) begin
      state_d = HOLD;
      cnt_d   = CNT_W'(REARM_START);
      idx_d   = '0;
      stg_d   = '0;
      crst0_d = 1'b1;
      srst0_d = 1'b1;
      app0_d  = '0;
      cause_d = (cause_clr ? 4'h0 : cause_q) | evt_cause;
      if (cause_clr) count_d = 8'd1;
      else if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end else if (cause_clr) begin
      cause_d = '0;
      count_d = '0;
    end
  end

  // one output register stage on every reset output
  always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
    if (!any_rstn_rr) begin
      crst     <= 1'b1;
      srst     <= 1'b1;
      app_rstn <= '0;
    end else begin
      crst     <= crst0_q;
      srst     <= srst0_q;
      app_rstn <= app0_q;
    end
  end

  assign rst_busy   = crst | ~&app_rstn;
  assign exit_cause = cause_q;
  assign exit_count = count_q;

endmodule
